// File: rtl/led_counter_pkg.sv
// -----------------------------------------------------------------------------
// led_counter_pkg
// Shared definitions for the LED bar counter:
//   - display mode encodings (bar / binary)
//   - repeat FSM state encodings for the button auto-repeat logic
//   - clog2 / timer_width helpers used to size debounce and repeat timers
// No ports; imported by led_bar_counter and button_debounce.
// -----------------------------------------------------------------------------
package led_counter_pkg;

  // Display mode, as driven on the mode input
  localparam logic MODE_BAR = 1'b0;
  localparam logic MODE_BIN = 1'b1;

  // Auto-repeat FSM states
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3
  function automatic int clog2(input int n);
    longint unsigned v;
    int              r;
    v = 1;
    r = 0;
    while (v < longint'(n)) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Width of a counter that runs 0 .. n-1; never narrower than one bit
  function automatic int timer_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Conditions one raw push-button into single-cycle event pulses:
//   2-flop synchroniser -> polarity normalise (pressed = 1) -> debounce
//   -> rising-edge detect -> optional hold-to-auto-repeat FSM.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   i_button  in   raw, asynchronous button pin
//   o_event   out  registered 1-cycle event pulse (press and, when
//                  REPEAT_EN != 0, auto-repeat events while held)
//
// Timing: the accepted level rises at edge E0, o_event is high for the
// cycle following edge E1. Repeat events follow REPEAT_DELAY cycles after
// the press event and then every REPEAT_PERIOD cycles.
// -----------------------------------------------------------------------------
module button_debounce
  import led_counter_pkg::*;
#(
  parameter int BUTTON_ACTIVE_LOW = 1,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int REPEAT_DELAY      = 25000000,
  parameter int REPEAT_PERIOD     = 5000000,
  parameter int REPEAT_EN         = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_button,
  output logic o_event
);

  localparam int DB_W = timer_width(DEBOUNCE_CYCLES);
  localparam int RT_W = timer_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                    REPEAT_DELAY : REPEAT_PERIOD);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RT_W-1:0] DELAY_LAST  = RT_W'(REPEAT_DELAY - 1);
  localparam logic [RT_W-1:0] PERIOD_LAST = RT_W'(REPEAT_PERIOD - 1);

  // Raw pin level while the button is released
  localparam logic RELEASED_RAW = (BUTTON_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [1:0]      r_sync;
  logic            w_sample;
  logic            r_level;
  logic            r_level_d;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_rise;
  rpt_state_e      r_state;
  logic [RT_W-1:0] r_timer;
  logic            r_event;

  // --- synchroniser stage -----------------------------------------------
  // Reset to the released pin level so that a button held through reset
  // is seen as a fresh press afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {RELEASED_RAW, RELEASED_RAW};
    end else begin
      r_sync <= {r_sync[0], i_button};
    end
  end

  // XOR with the released level turns "pressed" into 1 for either polarity
  assign w_sample = r_sync[1] ^ RELEASED_RAW;

  // --- debounce stage ---------------------------------------------------
  // The accepted level moves only after DEBOUNCE_CYCLES consecutive samples
  // that disagree with it; a single agreeing sample restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level  <= 1'b0;
      r_db_cnt <= '0;
    end else if (w_sample == r_level) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_level  <= w_sample;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // --- edge detect stage ------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
    end
  end

  assign w_rise = r_level & ~r_level_d;

  // --- repeat FSM stage -------------------------------------------------
  // The press event is emitted on the IDLE->DELAY transition. Without
  // REPEAT_EN the FSM never leaves IDLE, so only press events appear.
  // A released level is checked before the timers so no event can follow
  // an accepted release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RPT_IDLE;
      r_timer <= '0;
      r_event <= 1'b0;
    end else begin
      r_event <= 1'b0;
      case (r_state)
        RPT_IDLE: begin
          if (w_rise) begin
            r_event <= 1'b1;
            r_timer <= '0;
            if (REPEAT_EN != 0) begin
              r_state <= RPT_DELAY;
            end
          end
        end
        RPT_DELAY: begin
          if (!r_level) begin
            r_state <= RPT_IDLE;
            r_timer <= '0;
          end else if (r_timer == DELAY_LAST) begin
            r_event <= 1'b1;
            r_timer <= '0;
            r_state <= RPT_REPEAT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (!r_level) begin
            r_state <= RPT_IDLE;
            r_timer <= '0;
          end else if (r_timer == PERIOD_LAST) begin
            r_event <= 1'b1;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= RPT_IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign o_event = r_event;

endmodule

// File: rtl/led_bar_counter.sv
// -----------------------------------------------------------------------------
// led_bar_counter
// Up/down counter driven by three push-buttons with its value shown on LEDs.
// Supports saturate or wrap at the limits, hold-to-auto-repeat on inc/dec,
// and a runtime bar / binary display mode.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   inc_button  in   raw increment button (auto-repeats while held)
//   dec_button  in   raw decrement button (auto-repeats while held)
//   clr_button  in   raw clear button (no repeat)
//   mode        in   0 = bar display, 1 = binary display (quasi-static)
//   value       out  current count, registered
//   leds        out  LED drive, registered one cycle after value
//   at_max      out  value == MAX, registered alongside value
//   at_min      out  value == 0, registered alongside value
// -----------------------------------------------------------------------------
module led_bar_counter
  import led_counter_pkg::*;
#(
  parameter int CNT_WIDTH         = 3,
  parameter int NUM_LEDS          = 8,
  parameter int WRAP              = 0,
  parameter int BUTTON_ACTIVE_LOW = 1,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int REPEAT_DELAY      = 25000000,
  parameter int REPEAT_PERIOD     = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc_button,
  input  logic                 dec_button,
  input  logic                 clr_button,
  input  logic                 mode,
  output logic [CNT_WIDTH-1:0] value,
  output logic [NUM_LEDS-1:0]  leds,
  output logic                 at_max,
  output logic                 at_min
);

  localparam logic [CNT_WIDTH-1:0] MAX_VAL = '1;
  localparam int BIN_W = (CNT_WIDTH < NUM_LEDS) ? CNT_WIDTH : NUM_LEDS;

  logic                 w_inc_evt;
  logic                 w_dec_evt;
  logic                 w_clr_evt;
  logic [CNT_WIDTH-1:0] w_next;
  logic [CNT_WIDTH-1:0] r_value;
  logic                 r_at_max;
  logic                 r_at_min;
  logic [NUM_LEDS-1:0]  r_leds;

  // Next count for one cycle's events. Clear dominates; simultaneous
  // inc and dec cancel; the limits either hold or wrap around.
  function automatic logic [CNT_WIDTH-1:0] next_value(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 inc,
    input logic                 dec,
    input logic                 clr
  );
    logic [CNT_WIDTH-1:0] nv;
    nv = cur;
    if (clr) begin
      nv = '0;
    end else if (inc && dec) begin
      nv = cur;
    end else if (inc) begin
      if (cur == MAX_VAL) begin
        nv = (WRAP != 0) ? '0 : MAX_VAL;
      end else begin
        nv = cur + 1'b1;
      end
    end else if (dec) begin
      if (cur == '0) begin
        nv = (WRAP != 0) ? MAX_VAL : '0;
      end else begin
        nv = cur - 1'b1;
      end
    end
    return nv;
  endfunction

  // Thermometer code: the lowest `v` LEDs lit; saturates at all-on
  function automatic logic [NUM_LEDS-1:0] bar_pattern(
    input logic [CNT_WIDTH-1:0] v
  );
    logic [NUM_LEDS-1:0] p;
    for (int i = 0; i < NUM_LEDS; i++) begin
      p[i] = (i < int'(v));
    end
    return p;
  endfunction

  // Binary code on the low LEDs; LEDs beyond the counter width stay dark
  function automatic logic [NUM_LEDS-1:0] bin_pattern(
    input logic [CNT_WIDTH-1:0] v
  );
    logic [NUM_LEDS-1:0] p;
    p            = '0;
    p[BIN_W-1:0] = v[BIN_W-1:0];
    return p;
  endfunction

  // --- button conditioning stage ----------------------------------------
  button_debounce #(
    .BUTTON_ACTIVE_LOW (BUTTON_ACTIVE_LOW),
    .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
    .REPEAT_DELAY      (REPEAT_DELAY),
    .REPEAT_PERIOD     (REPEAT_PERIOD),
    .REPEAT_EN         (1)
  ) u_inc (
    .clk      (clk),
    .reset    (reset),
    .i_button (inc_button),
    .o_event  (w_inc_evt)
  );

  button_debounce #(
    .BUTTON_ACTIVE_LOW (BUTTON_ACTIVE_LOW),
    .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
    .REPEAT_DELAY      (REPEAT_DELAY),
    .REPEAT_PERIOD     (REPEAT_PERIOD),
    .REPEAT_EN         (1)
  ) u_dec (
    .clk      (clk),
    .reset    (reset),
    .i_button (dec_button),
    .o_event  (w_dec_evt)
  );

  button_debounce #(
    .BUTTON_ACTIVE_LOW (BUTTON_ACTIVE_LOW),
    .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
    .REPEAT_DELAY      (REPEAT_DELAY),
    .REPEAT_PERIOD     (REPEAT_PERIOD),
    .REPEAT_EN         (0)
  ) u_clr (
    .clk      (clk),
    .reset    (reset),
    .i_button (clr_button),
    .o_event  (w_clr_evt)
  );

  // --- counter stage ----------------------------------------------------
  assign w_next = next_value(r_value, w_inc_evt, w_dec_evt, w_clr_evt);

  // Flags are derived from the next value so they change with value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value  <= '0;
      r_at_max <= 1'b0;
      r_at_min <= 1'b1;
    end else begin
      r_value  <= w_next;
      r_at_max <= (w_next == MAX_VAL);
      r_at_min <= (w_next == '0);
    end
  end

  // --- display stage ----------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_leds <= '0;
    end else if (mode == MODE_BIN) begin
      r_leds <= bin_pattern(r_value);
    end else begin
      r_leds <= bar_pattern(r_value);
    end
  end

  assign value  = r_value;
  assign leds   = r_leds;
  assign at_max = r_at_max;
  assign at_min = r_at_min;

endmodule

// File: tb/tb_led_bar_counter.sv
// -----------------------------------------------------------------------------
// tb_led_bar_counter
// Drives a saturating and a wrapping led_bar_counter from the same buttons
// and compares both against a press-level reference model: each press held
// for H clock cycles yields one press event plus repeat events at offsets
// REPEAT_DELAY, +REPEAT_PERIOD, ... that fall before H.
// -----------------------------------------------------------------------------
module tb_led_bar_counter;

  localparam int CW     = 3;
  localparam int NL     = 8;
  localparam int DEB    = 4;
  localparam int RD     = 20;
  localparam int RP     = 5;
  localparam int MAXV   = (1 << CW) - 1;
  localparam int SETTLE = 14;

  logic          clk;
  logic          reset;
  logic          inc_b;
  logic          dec_b;
  logic          clr_b;
  logic          mode;
  logic [CW-1:0] v_s;
  logic [CW-1:0] v_w;
  logic [NL-1:0] l_s;
  logic [NL-1:0] l_w;
  logic          mx_s;
  logic          mn_s;
  logic          mx_w;
  logic          mn_w;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_s    = 0;
  int exp_w    = 0;

  led_bar_counter #(
    .CNT_WIDTH (CW), .NUM_LEDS (NL), .WRAP (0), .BUTTON_ACTIVE_LOW (1),
    .DEBOUNCE_CYCLES (DEB), .REPEAT_DELAY (RD), .REPEAT_PERIOD (RP)
  ) dut_sat (
    .clk (clk), .reset (reset), .inc_button (inc_b), .dec_button (dec_b),
    .clr_button (clr_b), .mode (mode), .value (v_s), .leds (l_s),
    .at_max (mx_s), .at_min (mn_s)
  );

  led_bar_counter #(
    .CNT_WIDTH (CW), .NUM_LEDS (NL), .WRAP (1), .BUTTON_ACTIVE_LOW (1),
    .DEBOUNCE_CYCLES (DEB), .REPEAT_DELAY (RD), .REPEAT_PERIOD (RP)
  ) dut_wrap (
    .clk (clk), .reset (reset), .inc_button (inc_b), .dec_button (dec_b),
    .clr_button (clr_b), .mode (mode), .value (v_w), .leds (l_w),
    .at_max (mx_w), .at_min (mn_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Events produced by a press held for `hold` cycles
  function automatic int n_events(input int hold);
    int n;
    if (hold < DEB) return 0;
    n = 1;
    if (hold > RD) n = n + 1 + (hold - RD - 1) / RP;
    return n;
  endfunction

  // Counter rule for one cycle's events
  function automatic int step(input int v, input bit i, input bit d,
                              input bit c, input bit wrap);
    if (c) return 0;
    if (i && d) return v;
    if (i) return (v == MAXV) ? (wrap ? 0 : MAXV) : v + 1;
    if (d) return (v == 0) ? (wrap ? MAXV : 0) : v - 1;
    return v;
  endfunction

  function automatic logic [NL-1:0] leds_exp(input int v, input bit m);
    if (m) return NL'(v);
    if (v >= NL) return '1;
    return NL'((1 << v) - 1);
  endfunction

  // Press the chosen buttons together for `hold` cycles, release, settle.
  // Called just after a rising edge.
  task automatic press(input bit pi, input bit pd, input bit pc,
                       input int hold, input int settle);
    int n;
    if (pi) inc_b = 1'b0;
    if (pd) dec_b = 1'b0;
    if (pc) clr_b = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    inc_b = 1'b1;
    dec_b = 1'b1;
    clr_b = 1'b1;
    repeat (settle) @(posedge clk);
    #1;
    n = n_events(hold);
    for (int j = 0; j < n; j++) begin
      exp_s = step(exp_s, pi, pd, pc && (j == 0), 1'b0);
      exp_w = step(exp_w, pi, pd, pc && (j == 0), 1'b1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inc_b = 1'b1;
    dec_b = 1'b1;
    clr_b = 1'b1;
    mode  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({v_s, l_s, mx_s, mn_s} !== {3'd0, 8'd0, 1'b0, 1'b1})
      $display("FAIL reset_sat: got v=%0d leds=%b max=%b min=%b required 0 0 0 1",
               v_s, l_s, mx_s, mn_s);
    else n_pass++;
    n_checks++;
    if ({v_w, l_w, mx_w, mn_w} !== {3'd0, 8'd0, 1'b0, 1'b1})
      $display("FAIL reset_wrap: got v=%0d leds=%b max=%b min=%b required 0 0 0 1",
               v_w, l_w, mx_w, mn_w);
    else n_pass++;
    reset = 1'b0;
    exp_s = 0;
    exp_w = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 3; k++) begin
      press(1'b1, 1'b0, 1'b0, 10, SETTLE);
    end
    n_checks++;
    if (v_s !== CW'(exp_s)) $display("FAIL basic_value: got %0d required %0d", v_s, exp_s);
    else n_pass++;
    n_checks++;
    if (l_s !== leds_exp(exp_s, 1'b0))
      $display("FAIL basic_bar: got %b required %b", l_s, leds_exp(exp_s, 1'b0));
    else n_pass++;
    mode = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (l_s !== leds_exp(exp_s, 1'b1))
      $display("FAIL basic_bin: got %b required %b", l_s, leds_exp(exp_s, 1'b1));
    else n_pass++;
    mode = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_glitch();
    int nb;
    // Short glitch alone
    press(1'b1, 1'b0, 1'b0, $urandom_range(1, DEB - 1), SETTLE);
    n_checks++;
    if (v_s !== CW'(exp_s)) $display("FAIL glitch_only: got %0d required %0d", v_s, exp_s);
    else n_pass++;
    // Bouncy press then bouncy release: one event only
    nb = $urandom_range(1, 3);
    for (int b = 0; b < nb; b++) begin
      inc_b = 1'b0;
      repeat ($urandom_range(1, DEB - 1)) @(posedge clk);
      #1;
      inc_b = 1'b1;
      repeat ($urandom_range(1, DEB - 1)) @(posedge clk);
      #1;
    end
    inc_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    nb = $urandom_range(1, 2);
    for (int b = 0; b < nb; b++) begin
      inc_b = 1'b1;
      repeat ($urandom_range(1, DEB - 1)) @(posedge clk);
      #1;
      inc_b = 1'b0;
      repeat ($urandom_range(1, DEB - 1)) @(posedge clk);
      #1;
    end
    inc_b = 1'b1;
    repeat (SETTLE) @(posedge clk);
    #1;
    exp_s = step(exp_s, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_w = step(exp_w, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (v_s !== CW'(exp_s)) $display("FAIL bounce_sat: got %0d required %0d", v_s, exp_s);
    else n_pass++;
    n_checks++;
    if (v_w !== CW'(exp_w)) $display("FAIL bounce_wrap: got %0d required %0d", v_w, exp_w);
    else n_pass++;
  endtask

  task automatic test_limits();
    press(1'b0, 1'b0, 1'b1, 5, SETTLE);
    for (int k = 0; k < 9; k++) begin
      press(1'b1, 1'b0, 1'b0, $urandom_range(DEB, 15), SETTLE);
    end
    n_checks++;
    if ({v_s, mx_s, l_s} !== {CW'(exp_s), 1'b1, leds_exp(exp_s, 1'b0)})
      $display("FAIL sat_top: got v=%0d max=%b leds=%b required %0d 1 %b",
               v_s, mx_s, l_s, exp_s, leds_exp(exp_s, 1'b0));
    else n_pass++;
    n_checks++;
    if (v_w !== CW'(exp_w)) $display("FAIL wrap_nine: got %0d required %0d", v_w, exp_w);
    else n_pass++;
    press(1'b0, 1'b0, 1'b1, 5, SETTLE);
    press(1'b0, 1'b1, 1'b0, 6, SETTLE);
    n_checks++;
    if ({v_s, mn_s} !== {CW'(exp_s), 1'b1})
      $display("FAIL sat_bottom: got v=%0d min=%b required %0d 1", v_s, mn_s, exp_s);
    else n_pass++;
    n_checks++;
    if ({v_w, mx_w} !== {CW'(exp_w), 1'b1})
      $display("FAIL wrap_under: got v=%0d max=%b required %0d 1", v_w, mx_w, exp_w);
    else n_pass++;
    press(1'b1, 1'b0, 1'b0, 6, SETTLE);
    n_checks++;
    if ({v_w, mn_w} !== {CW'(exp_w), 1'b1})
      $display("FAIL wrap_over: got v=%0d min=%b required %0d 1", v_w, mn_w, exp_w);
    else n_pass++;
  endtask

  task automatic test_repeat();
    press(1'b0, 1'b0, 1'b1, 5, SETTLE);
    inc_b = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if (v_s !== CW'(exp_s)) $display("FAIL rpt_latency_early: got %0d required %0d", v_s, exp_s);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (v_s !== CW'(exp_s + 1)) $display("FAIL rpt_first: got %0d required %0d", v_s, exp_s + 1);
    else n_pass++;
    repeat (RD - 1) @(posedge clk);
    #1;
    n_checks++;
    if (v_s !== CW'(exp_s + 1)) $display("FAIL rpt_before_delay: got %0d required %0d", v_s, exp_s + 1);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (v_s !== CW'(exp_s + 2)) $display("FAIL rpt_after_delay: got %0d required %0d", v_s, exp_s + 2);
    else n_pass++;
    repeat (37 - 8 - RD) @(posedge clk);
    #1;
    inc_b = 1'b1;
    repeat (SETTLE) @(posedge clk);
    #1;
    for (int j = 0; j < n_events(37); j++) begin
      exp_s = step(exp_s, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_w = step(exp_w, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    n_checks++;
    if (v_s !== CW'(exp_s)) $display("FAIL rpt_total: got %0d required %0d", v_s, exp_s);
    else n_pass++;
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (v_w !== CW'(exp_w)) $display("FAIL rpt_after_release: got %0d required %0d", v_w, exp_w);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    press(1'b0, 1'b0, 1'b1, 5, SETTLE);
    for (int k = 0; k < 4; k++) press(1'b1, 1'b0, 1'b0, 6, SETTLE);
    press(1'b1, 1'b1, 1'b0, $urandom_range(DEB, 30), SETTLE);
    n_checks++;
    if (v_s !== CW'(exp_s)) $display("FAIL inc_dec_same: got %0d required %0d", v_s, exp_s);
    else n_pass++;
    press(1'b1, 1'b0, 1'b1, 6, SETTLE);
    n_checks++;
    if (v_w !== CW'(exp_w)) $display("FAIL clr_inc_same: got %0d required %0d", v_w, exp_w);
    else n_pass++;
    press(1'b1, 1'b0, 1'b1, 28, SETTLE);
    n_checks++;
    if (v_s !== CW'(exp_s)) $display("FAIL clr_no_repeat: got %0d required %0d", v_s, exp_s);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    press(1'b0, 1'b0, 1'b1, 5, SETTLE);
    inc_b = 1'b0;
    repeat (43) @(posedge clk);
    #1;
    n_checks++;
    if (v_s !== CW'(5)) $display("FAIL mid_before_reset: got %0d required 5", v_s);
    else n_pass++;
    repeat (2) @(posedge clk);
    #4;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({v_s, l_s, mn_s, v_w, l_w} !== {3'd0, 8'd0, 1'b1, 3'd0, 8'd0})
      $display("FAIL mid_async_clear: got v=%0d leds=%b min=%b vw=%0d lw=%b required 0",
               v_s, l_s, mn_s, v_w, l_w);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_s = 0;
    exp_w = 0;
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if (v_s !== 3'd0) $display("FAIL mid_repress_early: got %0d required 0", v_s);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (v_s !== 3'd1) $display("FAIL mid_repress: got %0d required 1", v_s);
    else n_pass++;
    repeat (RD) @(posedge clk);
    #1;
    n_checks++;
    if (v_w !== 3'd2) $display("FAIL mid_repeat_resume: got %0d required 2", v_w);
    else n_pass++;
    repeat (30 - 8 - RD) @(posedge clk);
    #1;
    inc_b = 1'b1;
    repeat (SETTLE) @(posedge clk);
    #1;
    for (int j = 0; j < n_events(30); j++) begin
      exp_s = step(exp_s, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_w = step(exp_w, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    n_checks++;
    if (v_s !== CW'(exp_s)) $display("FAIL mid_final: got %0d required %0d", v_s, exp_s);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int kind;
      int hold;
      kind = $urandom_range(0, 6);
      mode = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(RD + 1, 45)
                                         : $urandom_range(DEB, 18);
      case (kind)
        0, 1: press(1'b1, 1'b0, 1'b0, hold, SETTLE);
        2:    press(1'b0, 1'b1, 1'b0, hold, SETTLE);
        3:    press(1'b0, 1'b0, 1'b1, hold, SETTLE);
        4:    press(1'b1, 1'b1, 1'b0, hold, SETTLE);
        5:    press(1'b1, 1'b0, 1'b1, hold, SETTLE);
        default: press(1'($urandom_range(0, 1)), 1'b1, 1'b0,
                       $urandom_range(1, DEB - 1), SETTLE);
      endcase
      n_checks++;
      if ({v_s, l_s, mx_s, mn_s} !==
          {CW'(exp_s), leds_exp(exp_s, mode), exp_s == MAXV, exp_s == 0})
        $display("FAIL rand_sat it=%0d: got v=%0d leds=%b max=%b min=%b required v=%0d leds=%b",
                 it, v_s, l_s, mx_s, mn_s, exp_s, leds_exp(exp_s, mode));
      else n_pass++;
      n_checks++;
      if ({v_w, l_w, mx_w, mn_w} !==
          {CW'(exp_w), leds_exp(exp_w, mode), exp_w == MAXV, exp_w == 0})
        $display("FAIL rand_wrap it=%0d: got v=%0d leds=%b max=%b min=%b required v=%0d leds=%b",
                 it, v_w, l_w, mx_w, mn_w, exp_w, leds_exp(exp_w, mode));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_limits();
    test_repeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
